// File: rtl/jk_cmd_sequencer.sv
// Command sequencer for an external JK flip-flop: buffers {j,k} commands, issues
// one per slot, and checks the fed-back q against a tracked expected state.
module jk_cmd_sequencer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_cmd_valid,
  input  logic [1:0]               i_cmd,
  output logic                     o_cmd_ready,
  input  logic                     i_q,
  output logic                     o_j,
  output logic                     o_k,
  output logic                     o_exp_q,
  output logic                     o_exp_valid,
  input  logic                     i_clr_err,
  output logic                     o_err,
  output logic [CNT_W-1:0]         o_err_cnt,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_busy
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_CHECK} state_t;

  logic [1:0]       r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_level;
  state_t           r_state;
  logic             r_j;
  logic             r_k;
  logic             r_exp_q;
  logic             r_exp_valid;
  logic             r_chk_en;
  logic             r_err;
  logic [CNT_W-1:0] r_err_cnt;

  logic             w_full;
  logic             w_push;
  logic             w_pop;
  logic [1:0]       w_head;
  logic             w_mismatch;

  assign w_full      = (r_level == (AW+1)'(DEPTH));
  assign o_cmd_ready = !w_full;
  assign w_push      = i_cmd_valid && !w_full;
  // IDLE and CHECK both hand the head command to ISSUE whenever one is queued.
  assign w_pop       = (r_state != S_ISSUE) && (r_level != '0);
  assign w_head      = r_mem[r_rd_ptr];
  assign w_mismatch  = (r_state == S_CHECK) && r_chk_en && (i_q != r_exp_q);

  // NOTE: the storage array has no reset; occupancy is tracked by r_level, so stale entries are never read.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_cmd;
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + (AW+1)'(1);
        2'b01:   r_level <= r_level - (AW+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_j         <= 1'b0;
      r_k         <= 1'b0;
      r_exp_q     <= 1'b0;
      r_exp_valid <= 1'b0;
      r_chk_en    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            {r_j, r_k} <= w_head;
            r_state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          {r_j, r_k} <= 2'b00;
          // Check enable captures validity as it stood before this command's update.
          r_chk_en   <= r_exp_valid;
          case ({r_j, r_k})
            2'b01:   begin r_exp_q <= 1'b0; r_exp_valid <= 1'b1; end
            2'b10:   begin r_exp_q <= 1'b1; r_exp_valid <= 1'b1; end
            2'b11:   r_exp_q <= ~r_exp_q;
            default: r_exp_q <= r_exp_q;
          endcase
          r_state <= S_CHECK;
        end
        S_CHECK: begin
          if (w_pop) begin
            {r_j, r_k} <= w_head;
            r_state    <= S_ISSUE;
          end else begin
            r_state    <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err     <= 1'b0;
      r_err_cnt <= '0;
    end else if (i_clr_err && w_mismatch) begin
      r_err     <= 1'b1;
      r_err_cnt <= CNT_W'(1);
    end else if (i_clr_err) begin
      r_err     <= 1'b0;
      r_err_cnt <= '0;
    end else if (w_mismatch) begin
      r_err     <= 1'b1;
      if (r_err_cnt != {CNT_W{1'b1}}) r_err_cnt <= r_err_cnt + CNT_W'(1);
    end
  end

  assign o_j         = r_j;
  assign o_k         = r_k;
  assign o_exp_q     = r_exp_q;
  assign o_exp_valid = r_exp_valid;
  assign o_err       = r_err;
  assign o_err_cnt   = r_err_cnt;
  assign o_level     = r_level;
  assign o_busy      = (r_state != S_IDLE) || (r_level != '0);

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// Scoreboard bench for jk_cmd_sequencer with a behavioural JK flip-flop closing the q loop.
module tb_jk_cmd_sequencer;
  localparam int DEPTH = 4;
  localparam int CNT_W = 8;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             i_cmd_valid = 1'b0;
  logic [1:0]       i_cmd = 2'b00;
  logic             o_cmd_ready;
  logic             w_q;
  logic             o_j, o_k, o_exp_q, o_exp_valid;
  logic             i_clr_err = 1'b0;
  logic             o_err;
  logic [CNT_W-1:0] o_err_cnt;
  logic [LW-1:0]    o_level;
  logic             o_busy;

  always #5 clk = ~clk;

  jk_cmd_sequencer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .i_cmd_valid(i_cmd_valid), .i_cmd(i_cmd),
    .o_cmd_ready(o_cmd_ready), .i_q(w_q), .o_j(o_j), .o_k(o_k),
    .o_exp_q(o_exp_q), .o_exp_valid(o_exp_valid), .i_clr_err(i_clr_err),
    .o_err(o_err), .o_err_cnt(o_err_cnt), .o_level(o_level), .o_busy(o_busy)
  );

  // Behavioural flip-flop (no reset) with an optional stuck-at-0 output fault.
  logic r_ff;
  logic stuck0 = 1'b0;
  always @(posedge clk)
    case ({o_j, o_k})
      2'b01:   r_ff <= 1'b0;
      2'b10:   r_ff <= 1'b1;
      2'b11:   r_ff <= ~r_ff;
      default: ;
    endcase
  assign w_q = stuck0 ? 1'b0 : r_ff;

  typedef struct packed {
    logic [1:0] jk;
    logic       exp_q;
    logic       exp_valid;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   n_total = 0;
  int   n_bad   = 0;
  int   cyc     = 0;
  bit   pend    = 1'b0;
  bit   spacing_on = 1'b0;
  int   prev_pulse = -1;
  int   last_pulse_cyc = -1;
  int   last_send_cyc  = -1;
  int   max_level = 0;
  logic m_exp_q = 1'b0;
  logic m_exp_valid = 1'b0;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Output monitor: pops the scoreboard on each j/k pulse and checks the tracked state a cycle later.
  always @(negedge clk) begin
    if (!rst) begin
      if (pend) begin
        check("pulse_width", {30'd0, o_j, o_k}, 32'd0);
        if (cur.exp_valid) check("exp_q", o_exp_q, cur.exp_q);
        check("exp_valid", o_exp_valid, cur.exp_valid);
        pend = 1'b0;
      end
      if (o_j || o_k) begin
        if (sb.size() == 0) begin
          check("sb_empty", {30'd0, o_j, o_k}, 32'd0);
        end else begin
          cur = sb.pop_front();
          check("issue_jk", {30'd0, o_j, o_k}, {30'd0, cur.jk});
          pend = 1'b1;
          if (spacing_on && prev_pulse >= 0) check("spacing", cyc - prev_pulse, 2);
          prev_pulse     = cyc;
          last_pulse_cyc = cyc;
        end
      end
      if (spacing_on) begin
        check("ready_vs_full", o_cmd_ready, (o_level != DEPTH));
        if (int'(o_level) > max_level) max_level = int'(o_level);
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    sb.delete();
    pend        = 1'b0;
    prev_pulse  = -1;
    m_exp_q     = 1'b0;
    m_exp_valid = 1'b0;
    i_cmd_valid = 1'b0;
    i_clr_err   = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_level", o_level, 0);
    check("rst_ready", o_cmd_ready, 1);
    check("rst_jk", {30'd0, o_j, o_k}, 0);
    check("rst_exp_valid", o_exp_valid, 0);
    check("rst_exp_q", o_exp_q, 0);
    check("rst_err", o_err, 0);
    check("rst_err_cnt", o_err_cnt, 0);
    check("rst_busy", o_busy, 0);
    rst = 1'b0;
  endtask

  task automatic send(input logic [1:0] c);
    int n;
    exp_t e;
    @(negedge clk);
    i_cmd       = c;
    i_cmd_valid = 1'b1;
    n = 0;
    while (!o_cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!o_cmd_ready) begin
      check("ready_timeout", 0, 1);
      i_cmd_valid = 1'b0;
      return;
    end
    case (c)
      2'b01:   begin m_exp_q = 1'b0; m_exp_valid = 1'b1; end
      2'b10:   begin m_exp_q = 1'b1; m_exp_valid = 1'b1; end
      2'b11:   m_exp_q = ~m_exp_q;
      default: ;
    endcase
    if (c != 2'b00) begin
      e.jk        = c;
      e.exp_q     = m_exp_q;
      e.exp_valid = m_exp_valid;
      sb.push_back(e);
    end
    last_send_cyc = cyc;
    @(posedge clk);
  endtask

  task automatic idle_and_wait();
    int n;
    @(negedge clk);
    i_cmd_valid = 1'b0;
    n = 0;
    while (o_busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (o_busy) check("idle_timeout", 0, 1);
    @(negedge clk);
  endtask

  task automatic wait_pulse();
    int n;
    n = 0;
    while (!(o_j || o_k) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!(o_j || o_k)) check("pulse_timeout", 0, 1);
  endtask

  logic [1:0] burst [8];

  initial begin
    burst = '{2'b10, 2'b11, 2'b01, 2'b11, 2'b11, 2'b10, 2'b01, 2'b11};

    // 1: single set, latency and final state
    do_reset();
    send(2'b10);
    idle_and_wait();
    check("t1_latency", last_pulse_cyc - last_send_cyc, 2);
    check("t1_q", w_q, 1);
    check("t1_exp_q", o_exp_q, 1);
    check("t1_exp_valid", o_exp_valid, 1);
    check("t1_err", o_err, 0);

    // 2: toggle and hold from unknown state, then clear
    do_reset();
    send(2'b11);
    send(2'b00);
    send(2'b01);
    idle_and_wait();
    check("t2_exp_q", o_exp_q, 0);
    check("t2_exp_valid", o_exp_valid, 1);
    check("t2_err", o_err, 0);

    // 3: back-to-back burst fills the FIFO; order and 2-cycle issue spacing
    do_reset();
    spacing_on = 1'b1;
    max_level  = 0;
    for (int i = 0; i < 8; i++) send(burst[i]);
    idle_and_wait();
    spacing_on = 1'b0;
    check("t3_max_level", max_level, DEPTH);
    check("t3_sb_drained", sb.size(), 0);
    check("t3_q", w_q, m_exp_q);
    check("t3_err", o_err, 0);

    // 4: q stuck at 0 -> mismatches, counter saturates
    do_reset();
    stuck0 = 1'b1;
    send(2'b01);
    send(2'b10);
    idle_and_wait();
    check("t4_err", o_err, 1);
    check("t4_err_cnt", o_err_cnt, 1);
    for (int i = 0; i < 300; i++) send(2'b10);
    idle_and_wait();
    check("t4_err_sat", o_err, 1);
    check("t4_err_cnt_sat", o_err_cnt, 255);

    // 5: clr_err coincident with a mismatch
    send(2'b10);
    @(negedge clk);
    i_cmd_valid = 1'b0;
    wait_pulse();
    @(negedge clk);
    i_clr_err = 1'b1;
    @(negedge clk);
    i_clr_err = 1'b0;
    check("t5_err", o_err, 1);
    check("t5_err_cnt", o_err_cnt, 1);
    stuck0 = 1'b0;
    idle_and_wait();

    // 6: reset during ISSUE discards everything
    do_reset();
    send(2'b10);
    send(2'b10);
    @(negedge clk);
    i_cmd_valid = 1'b0;
    wait_pulse();
    #2 rst = 1'b1;
    sb.delete();
    pend = 1'b0;
    #1;
    check("t6_jk_async", {30'd0, o_j, o_k}, 0);
    check("t6_level", o_level, 0);
    check("t6_busy", o_busy, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("t6_ready", o_cmd_ready, 1);
    check("t6_level_after", o_level, 0);
    repeat (6) @(negedge clk);
    check("t6_no_issue", {30'd0, o_j, o_k}, 0);
    check("t6_busy_after", o_busy, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
